// File: rtl/encode8to3_scan.sv
// Streaming 8-to-3 encoder: emits the index of every set bit of an accepted vector, one per handshake.
// Define ENCODE8TO3_MSB_FIRST_EN to scan highest bit first; default order is lowest bit first.
module encode8to3_scan (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] vec_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       sel1,
  output logic       sel2,
  output logic       sel3,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       zero_err
);

  typedef enum logic {StIdle, StScan} state_e;

  state_e     state;
  logic [7:0] pending;
  logic [2:0] idx;
  logic       single;
  logic       scan;

  // Later iterations win, so the loop direction sets the scan order.
  always_comb begin
    idx = 3'd0;
`ifdef ENCODE8TO3_MSB_FIRST_EN
    for (int i = 0; i < 8; i++) begin
      if (pending[i]) idx = i[2:0];
    end
`else
    for (int i = 7; i >= 0; i--) begin
      if (pending[i]) idx = i[2:0];
    end
`endif
  end

  always_comb begin
    single              = (pending != 8'd0) && ((pending & (pending - 8'd1)) == 8'd0);
    scan                = (state == StScan);
    in_ready            = !scan;
    out_valid           = scan;
    out_last            = scan && single;
    {sel1, sel2, sel3}  = scan ? idx : 3'b000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StIdle;
      pending  <= 8'd0;
      zero_err <= 1'b0;
    end else begin
      zero_err <= 1'b0;
      unique case (state)
        StIdle: begin
          if (in_valid) begin
            if (vec_in != 8'd0) begin
              pending <= vec_in;
              state   <= StScan;
            end else begin
              zero_err <= 1'b1;
            end
          end
        end
        StScan: begin
          if (out_ready) begin
            pending <= pending & ~(8'd1 << idx);
            if (single) state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_encode8to3_scan.sv
// Self-checking bench for encode8to3_scan: scoreboard of expected codes plus directed corner cases.
module tb_encode8to3_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] vec_in = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       sel1, sel2, sel3;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_last;
  logic       zero_err;

  encode8to3_scan dut (
    .clk       (clk),
    .rst       (rst),
    .vec_in    (vec_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel1      (sel1),
    .sel2      (sel2),
    .sel3      (sel3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .zero_err  (zero_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] code;
    logic       last;
  } exp_t;

  typedef struct {
    logic [7:0] vec;
    int         n;
  } vec_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] dec_acc;
  int         seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference order: ascending bit index, or descending for the MSB-first build.
  task automatic push_model(input logic [7:0] v);
    int   total;
    int   done;
    int   b;
    exp_t e;
    total = $countones(v);
    done  = 0;
    for (int k = 0; k < 8; k++) begin
`ifdef ENCODE8TO3_MSB_FIRST_EN
      b = 7 - k;
`else
      b = k;
`endif
      if (v[b]) begin
        done++;
        e.code = b[2:0];
        e.last = (done == total);
        sb.push_back(e);
      end
    end
  endtask

  // Monitor: every accepted code is popped and compared; idle codes must read zero.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_code", {28'd0, out_last, sel1, sel2, sel3}, 32'hdead);
        end else begin
          e = sb.pop_front();
          check("code", {29'd0, sel1, sel2, sel3}, {29'd0, e.code});
          check("last", {31'd0, out_last}, {31'd0, e.last});
          dec_acc = dec_acc | (8'd1 << {sel1, sel2, sel3});
          seen++;
        end
      end else if (!out_valid) begin
        check("idle_code", {29'd0, sel1, sel2, sel3}, 32'd0);
      end
    end
  end

  task automatic send(input logic [7:0] v);
    int c;
    c = 0;
    @(posedge clk); #1;
    while (!in_ready && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    vec_in   = v;
    in_valid = 1'b1;
    if (v != 8'd0) push_model(v);
    @(posedge clk); #1;
    in_valid = 1'b0;
    vec_in   = $urandom;  // ignored while scanning
  endtask

  task automatic drain(input bit rnd);
    bit ok;
    ok = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (!ok) check("drain_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
  endtask

  vec_t       tbl[12];
  logic [2:0] seq[4];

  initial begin
    tbl[0]  = '{8'h01, 1};  tbl[1]  = '{8'h02, 1};  tbl[2]  = '{8'h04, 1};
    tbl[3]  = '{8'h08, 1};  tbl[4]  = '{8'h10, 1};  tbl[5]  = '{8'h20, 1};
    tbl[6]  = '{8'h40, 1};  tbl[7]  = '{8'h80, 1};  tbl[8]  = '{8'h55, 4};
    tbl[9]  = '{8'hff, 8};  tbl[10] = '{8'h3c, 4};  tbl[11] = '{8'h81, 2};
    dec_acc = 8'd0;
    seen    = 0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_code", {29'd0, sel1, sel2, sel3}, 32'd0);
    check("rst_zero_err", {31'd0, zero_err}, 32'd0);

    // Single one-hot vector: one code with out_last.
    send(8'h01);
    drain(0);

    // Four codes on consecutive cycles, then one IDLE cycle.
`ifdef ENCODE8TO3_MSB_FIRST_EN
    seq[0] = 3'd7; seq[1] = 3'd5; seq[2] = 3'd2; seq[3] = 3'd1;
`else
    seq[0] = 3'd1; seq[1] = 3'd2; seq[2] = 3'd5; seq[3] = 3'd7;
`endif
    send(8'ha6);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("a6_valid", {31'd0, out_valid}, 32'd1);
      check("a6_code", {29'd0, sel1, sel2, sel3}, {29'd0, seq[k]});
      check("a6_last", {31'd0, out_last}, (k == 3) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    check("a6_idle_valid", {31'd0, out_valid}, 32'd0);
    check("a6_idle_ready", {31'd0, in_ready}, 32'd1);

    // Backpressure: first code held stable for five cycles.
    @(posedge clk); #1 out_ready = 1'b0;
    send(8'h81);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, out_valid}, 32'd1);
`ifdef ENCODE8TO3_MSB_FIRST_EN
      check("hold_code", {29'd0, sel1, sel2, sel3}, 32'd7);
`else
      check("hold_code", {29'd0, sel1, sel2, sel3}, 32'd0);
`endif
      check("hold_last", {31'd0, out_last}, 32'd0);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    drain(0);

    // All-zero vector: dropped with a one-cycle zero_err pulse.
    @(posedge clk); #1;
    vec_in = 8'h00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("zero_err_pulse", {31'd0, zero_err}, 32'd1);
    check("zero_out_valid", {31'd0, out_valid}, 32'd0);
    check("zero_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    check("zero_err_clear", {31'd0, zero_err}, 32'd0);
    check("zero_still_idle", {31'd0, out_valid}, 32'd0);

    // Reset after the third handshake discards remaining codes.
    @(posedge clk); #1;
    vec_in = 8'hff; in_valid = 1'b1;
    push_model(8'hff);
    @(posedge clk); #1;            // accepted at this edge
    in_valid = 1'b0;
    @(posedge clk);                // handshake 1
    @(posedge clk);                // handshake 2
    @(posedge clk); #1;            // handshake 3
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_seen", seen, 32'd0 + 3 + 1 + 4 + 2);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
      check("mid_rst_last", {31'd0, out_last}, 32'd0);
    end
    check("mid_rst_pending", {24'd0, dut.pending}, 32'd0);

    // Table: loop-back through a 3-to-8 decode, with random backpressure.
    for (int t = 0; t < 12; t++) begin
      dec_acc = 8'd0;
      seen    = 0;
      send(tbl[t].vec);
      drain(1);
      check("loop_decode", {24'd0, dec_acc}, {24'd0, tbl[t].vec});
      check("loop_count", seen, tbl[t].n);
    end

    check("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/encode8to3_scan.md
ENCODE8TO3_SCAN -- requirements
Module: encode8to3_scan

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  input  1  rising-edge clock; sole clock domain.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 vec_in  input  8  request vector; bit k set = code k requested.
REQ-005 in_valid  input  1  vec_in valid this cycle.
REQ-006 in_ready  output  1  block accepts vec_in this cycle.
REQ-007 sel1  output  1  code bit 2 (MSB); {sel1,sel2,sel3} is the 3-bit code.
REQ-008 sel2  output  1  code bit 1.
REQ-009 sel3  output  1  code bit 0 (LSB).
REQ-010 out_valid  output  1  {sel1,sel2,sel3} valid.
REQ-011 out_ready  input  1  consumer takes the code this cycle.
REQ-012 out_last  output  1  current code is the final one from the captured vector.
REQ-013 zero_err  output  1  one-cycle pulse: an all-zero vector was accepted and dropped.

Function
REQ-014 The block SHALL perform the inverse of the 3-to-8 decode: it emits the 3-bit index of every set bit of an accepted vector, one index per output handshake.
REQ-015 States SHALL be IDLE and SCAN only; the state is held in an internal register named pending[7:0].
REQ-016 IDLE: in_ready=1, out_valid=0; if in_valid=1 and vec_in!=0, the block SHALL load pending<=vec_in and go to SCAN.
REQ-017 IDLE with in_valid=1 and vec_in==0: the block SHALL stay in IDLE, leave pending unchanged, and assert zero_err for exactly the next cycle.
REQ-018 SCAN: in_ready=0, out_valid=1, {sel1,sel2,sel3} = index of the lowest set bit of pending (default order).
REQ-019 out_last SHALL be 1 in SCAN iff pending has exactly one bit set, and SHALL be 0 in IDLE.
REQ-020 Handshake: when out_valid=1 and out_ready=1, the block SHALL clear the emitted bit in pending at that edge; if out_last=1 it SHALL return to IDLE.
REQ-021 With out_ready=0 the outputs {sel1,sel2,sel3,out_valid,out_last} SHALL remain stable until the handshake.
REQ-022 Latency: the first code appears 1 cycle after acceptance; with out_ready held at 1, a vector with N set bits yields N consecutive codes, followed by 1 IDLE cycle before the next vector can be accepted.
REQ-023 vec_in and in_valid SHALL be ignored while in SCAN.
REQ-024 When out_valid=0 the code outputs SHALL read 3'b000.

Reset
REQ-025 While rst=1 at a clock edge, state SHALL go to IDLE, pending<=0, zero_err<=0; rst SHALL take priority over all handshakes.
REQ-026 After reset: in_ready=1, out_valid=0, out_last=0, {sel1,sel2,sel3}=000.
REQ-027 Reset asserted mid-SCAN SHALL discard all remaining codes; no code SHALL be emitted after the reset edge.

Configuration
REQ-028 Macro ENCODE8TO3_MSB_FIRST_EN: when defined, SCAN SHALL emit the highest set bit of pending first (descending order).
REQ-029 When the macro is undefined, the order SHALL be ascending, lowest bit first. All other behaviour is identical in both builds.

Verification
REQ-030 Reset, then vec_in=8'b0000_0001, in_valid=1 for 1 cycle, out_ready=1 -> one code 000 with out_last=1, then IDLE.
REQ-031 vec_in=8'b1010_0110, out_ready=1 -> codes 001,010,101,111 on consecutive cycles, out_last only on 111 (MSB build: 111,101,010,001, out_last on 001).
REQ-032 vec_in=8'b1000_0001, out_ready held 0 for 5 cycles -> code 000 held stable and out_valid=1; then out_ready=1 -> 000 then 111.
REQ-033 vec_in=8'h00 with in_valid=1 in IDLE -> zero_err=1 for 1 cycle, out_valid stays 0, in_ready stays 1.
REQ-034 vec_in=8'hFF, assert rst after the 3rd handshake -> out_valid=0 from the next cycle, pending=0, in_ready=1, no further codes.
REQ-035 Loop-back: drive all 8 one-hot vectors through the block into the 3-to-8 decoder -> decoder output equals the original vector in every case.
